// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU encodings, FSM states and instruction field positions
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_SUB  = 4'h4,
    OP_LI   = 4'h5,
    OP_ADDI = 4'h6,
    OP_BEQZ = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_e;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/cpu_decoder.sv
// cpu_decoder: opcode to ALU controls and instruction class flags
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output logic       alu_src,
  output logic [1:0] alu_ctrl,
  output logic       writes_rd,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_halt,
  output logic       illegal
);
  logic is_rtype;
  always_comb begin
    is_rtype  = op == OP_ADD || op == OP_AND || op == OP_OR || op == OP_SUB;
    writes_rd = is_rtype || op == OP_LI || op == OP_ADDI;
    alu_src   = op == OP_LI || op == OP_ADDI;
    alu_ctrl  = op == OP_AND ? ALU_AND :
                op == OP_SUB ? ALU_SUB :
                (op == OP_OR || op == OP_LI || op == OP_BEQZ) ? ALU_OR : ALU_ADD;
    is_branch = op == OP_BEQZ;
    is_jump   = op == OP_JMP;
    is_halt   = op == OP_HALT;
    illegal   = op >= 4'h9 && op <= 4'hE;
  end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle fetch/decode/execute sequencer driving the reg_file_alu datapath
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RADDR_W  = 4,
  parameter int PC_W     = 8,
  parameter int IMEM_LAT = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  output logic               instr_rd,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [15:0]        instr_data,
  input  logic               Zero,
  output logic [RADDR_W-1:0] RA1,
  output logic [RADDR_W-1:0] RA2,
  output logic [RADDR_W-1:0] WA,
  output logic [DATA_W-1:0]  immediate,
  output logic               write_enable,
  output logic               ALUsrc,
  output logic [1:0]         ALUControl,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op,
  output logic [PC_W-1:0]    pc
);
  state_e      state, state_n;
  logic [1:0]  lat_cnt;
  logic [15:0] ir, dec_in;
  logic [3:0]  op, rd, rs1, rs2;
  logic [7:0]  imm8;
  logic        wait_done, idle_start;
  logic        alu_src, writes_rd, is_branch, is_jump, is_halt, illegal;
  logic [1:0]  alu_ctrl;
  logic [PC_W-1:0] pc_next;
  // Operand outputs are loaded on the edge entering EXEC, so decode the ROM word directly in WAIT
  assign dec_in     = state == S_WAIT ? instr_data : ir;
  assign op         = dec_in[OP_LSB +: 4];
  assign rd         = dec_in[RD_LSB +: 4];
  assign rs1        = dec_in[RS1_LSB +: 4];
  assign rs2        = dec_in[RS2_LSB +: 4];
  assign imm8       = dec_in[IMM_LSB +: 8];
  assign wait_done  = lat_cnt == 2'(IMEM_LAT - 1);
  assign idle_start = (state == S_IDLE || state == S_HALTED) && start;
  assign pc_next    = (is_jump || (is_branch && Zero)) ? PC_W'(imm8) : pc + PC_W'(1);
  assign instr_addr = pc;
  cpu_decoder u_dec (
    .op        (op),
    .alu_src   (alu_src),
    .alu_ctrl  (alu_ctrl),
    .writes_rd (writes_rd),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .is_halt   (is_halt),
    .illegal   (illegal)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_HALTED: state_n = start ? S_FETCH : state;
      S_FETCH:          state_n = S_WAIT;
      S_WAIT:           state_n = wait_done ? S_EXEC : S_WAIT;
      S_EXEC:           state_n = is_halt ? S_HALTED : writes_rd ? S_WB : S_FETCH;
      S_WB:             state_n = S_FETCH;
      default:          state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      ir           <= '0;
      pc           <= '0;
      instr_rd     <= 1'b0;
      RA1          <= '0;
      RA2          <= '0;
      WA           <= '0;
      immediate    <= '0;
      write_enable <= 1'b0;
      ALUsrc       <= 1'b0;
      ALUControl   <= '0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      state        <= state_n;
      instr_rd     <= state_n == S_FETCH;
      busy         <= !(state_n == S_IDLE || state_n == S_HALTED);
      halted       <= state_n == S_HALTED;
      lat_cnt      <= state == S_WAIT ? lat_cnt + 2'd1 : 2'd0;
      write_enable <= state == S_EXEC && writes_rd && rd != 4'd0;
      if (idle_start) pc <= '0;
      if (state == S_WAIT && wait_done) begin
        ir <= instr_data;
        if (writes_rd || is_branch) begin
          RA1        <= op == OP_LI ? '0 : (op == OP_ADDI || is_branch) ? RADDR_W'(rd) : RADDR_W'(rs1);
          RA2        <= is_branch ? '0 : RADDR_W'(rs2);
          WA         <= RADDR_W'(rd);
          immediate  <= DATA_W'(imm8);
          ALUsrc     <= alu_src;
          ALUControl <= alu_ctrl;
        end
      end
      if (state == S_EXEC) begin
        illegal_op <= illegal_op | illegal;
        if (!writes_rd && !is_halt) pc <= pc_next;
      end
      if (state == S_WB) pc <= pc + PC_W'(1);
    end
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed bench with ROM and register-file/ALU models around two controllers
module tb_cpu_controller;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  int tests = 0;
  int fails = 0;
  logic [15:0] mem [256];
  logic rst_n1, rst_n2, start1, start2;
  logic rd1, zero1, we1, src1, busy1, halted1, ill1;
  logic [7:0] addr1, imm1, pc1;
  logic [15:0] data1;
  logic [3:0] ra1_1, ra2_1, wa1;
  logic [1:0] ctl1;
  logic rd2, zero2, we2, src2, busy2, halted2, ill2;
  logic [7:0] addr2, imm2, pc2;
  logic [15:0] data2;
  logic [3:0] ra1_2, ra2_2, wa2;
  logic [1:0] ctl2;
  cpu_controller u_dut1 (
    .CLK(CLK), .RST_N(rst_n1), .start(start1), .instr_rd(rd1), .instr_addr(addr1),
    .instr_data(data1), .Zero(zero1), .RA1(ra1_1), .RA2(ra2_1), .WA(wa1),
    .immediate(imm1), .write_enable(we1), .ALUsrc(src1), .ALUControl(ctl1),
    .busy(busy1), .halted(halted1), .illegal_op(ill1), .pc(pc1)
  );
  cpu_controller #(.IMEM_LAT(3)) u_dut2 (
    .CLK(CLK), .RST_N(rst_n2), .start(start2), .instr_rd(rd2), .instr_addr(addr2),
    .instr_data(data2), .Zero(zero2), .RA1(ra1_2), .RA2(ra2_2), .WA(wa2),
    .immediate(imm2), .write_enable(we2), .ALUsrc(src2), .ALUControl(ctl2),
    .busy(busy2), .halted(halted2), .illegal_op(ill2), .pc(pc2)
  );
  // ROM models: data is only valid in the exact latency slot, otherwise an illegal opcode
  logic v1 = 1'b0;
  logic [15:0] q1 = 16'h0;
  always @(posedge CLK) begin
    v1 <= rd1;
    q1 <= mem[addr1];
  end
  assign data1 = v1 ? q1 : 16'h9999;
  logic [2:0] v2 = 3'b0;
  logic [15:0] q2a = 16'h0, q2b = 16'h0, q2c = 16'h0;
  always @(posedge CLK) begin
    v2  <= {v2[1:0], rd2};
    q2a <= mem[addr2];
    q2b <= q2a;
    q2c <= q2b;
  end
  assign data2 = v2[2] ? q2c : 16'h9999;
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
    return c == 2'b00 ? (a & b) : c == 2'b01 ? (a | b) : c == 2'b10 ? (a + b) : (a - b);
  endfunction
  logic [7:0] rf1 [16] = '{default: 8'h0};
  logic [7:0] rf2 [16] = '{default: 8'h0};
  logic [7:0] res1, res2;
  assign res1  = alu(rf1[ra1_1], src1 ? imm1 : rf1[ra2_1], ctl1);
  assign res2  = alu(rf2[ra1_2], src2 ? imm2 : rf2[ra2_2], ctl2);
  assign zero1 = res1 == 8'h0;
  assign zero2 = res2 == 8'h0;
  int we_cnt1 = 0;
  always @(posedge CLK) begin
    if (we1) rf1[wa1] <= res1;
    if (we2) rf2[wa2] <= res2;
    if (we1) we_cnt1 <= we_cnt1 + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask
  int we_base;
  initial begin
    rst_n1 = 1'b0;
    rst_n2 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    clear_mem();
    #1;
    chk("reset_outs", {ra1_1, ra2_1, wa1, imm1, we1, src1, ctl1, pc1, rd1, busy1, halted1, ill1}, 64'h0);
    tick(2);
    rst_n1 = 1'b1;
    rst_n2 = 1'b1;
    // reset during WB of LI R1,0x11
    mem[0] = 16'h5111;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    chk("s1_fetch", {rd1, addr1}, {1'b1, 8'h00});
    tick(2);
    chk("s1_exec_ctrl", {ra1_1, imm1, src1, ctl1}, {4'h0, 8'h11, 1'b1, 2'b01});
    tick(1);
    chk("s1_wb", {we1, wa1}, {1'b1, 4'h1});
    rst_n1 = 1'b0;
    #1;
    chk("s1_rst_we", we1, 1'b0);
    chk("s1_rst_outs", {ra1_1, ra2_1, wa1, imm1, src1, ctl1, pc1, rd1, busy1, halted1, ill1}, 64'h0);
    tick(1);
    chk("s1_r1_unwritten", rf1[1], 8'h00);
    rst_n1 = 1'b1;
    // LI/LI/ADD/HALT
    clear_mem();
    mem[0] = 16'h5111;
    mem[1] = 16'h5222;
    mem[2] = 16'h1312;
    mem[3] = 16'hF000;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(14);
    chk("s2_not_yet_halted", {halted1, busy1}, 2'b01);
    tick(1);
    chk("s2_halted", {halted1, busy1}, 2'b10);
    chk("s2_pc", pc1, 8'h03);
    chk("s2_r3", rf1[3], 8'h33);
    // branch taken on Zero
    clear_mem();
    mem[0]    = 16'h5333;
    mem[1]    = 16'h5444;
    mem[2]    = 16'h2534;
    mem[3]    = 16'h7510;
    mem[4]    = 16'hF000;
    mem[8'h10] = 16'h3634;
    mem[8'h11] = 16'hF000;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    chk("s3_restart", {halted1, busy1, pc1}, {1'b0, 1'b1, 8'h00});
    for (int i = 0; i < 200 && !halted1; i++) tick(1);
    chk("s3_halted", halted1, 1'b1);
    chk("s3_r5", rf1[5], 8'h00);
    chk("s3_r6", rf1[6], 8'h77);
    chk("s3_pc", pc1, 8'h11);
    // branch not taken, JMP 0xFF, wrap to 0
    clear_mem();
    mem[0]     = 16'h5111;
    mem[1]     = 16'h7120;
    mem[2]     = 16'h80FF;
    mem[3]     = 16'hF000;
    mem[8'h20] = 16'hF000;
    mem[8'hFF] = 16'h0000;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(7);
    chk("s4_beqz_not_taken", pc1, 8'h02);
    tick(3);
    chk("s4_jmp", {pc1, addr1, rd1}, {8'hFF, 8'hFF, 1'b1});
    tick(3);
    chk("s4_wrap", {pc1, busy1}, {8'h00, 1'b1});
    rst_n1 = 1'b0;
    tick(1);
    rst_n1 = 1'b1;
    // illegal opcode, LI R0, start while busy
    clear_mem();
    mem[0] = 16'hA123;
    mem[1] = 16'h5055;
    mem[2] = 16'hF000;
    we_base = we_cnt1;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(3);
    chk("s5_illegal_set", ill1, 1'b1);
    start1 = 1'b1;
    tick(2);
    start1 = 1'b0;
    tick(4);
    chk("s5_not_yet_halted", halted1, 1'b0);
    tick(1);
    chk("s5_halted", {halted1, pc1}, {1'b1, 8'h02});
    chk("s5_illegal_sticky", ill1, 1'b1);
    chk("s5_no_we", we_cnt1 - we_base, 0);
    chk("s5_r0", rf1[0], 8'h00);
    rst_n1 = 1'b0;
    tick(1);
    chk("s5_illegal_cleared", ill1, 1'b0);
    rst_n1 = 1'b1;
    // IMEM_LAT=3 instance
    clear_mem();
    mem[0] = 16'h5111;
    mem[1] = 16'h5222;
    mem[2] = 16'h1312;
    mem[3] = 16'hF000;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(3);
    chk("s6_still_waiting", src2, 1'b0);
    tick(1);
    chk("s6_latched", {src2, imm2, ctl2}, {1'b1, 8'h11, 2'b01});
    tick(18);
    chk("s6_not_yet_halted", halted2, 1'b0);
    tick(1);
    chk("s6_halted", {halted2, pc2}, {1'b1, 8'h03});
    chk("s6_r1", rf2[1], 8'h11);
    chk("s6_r3", rf2[3], 8'h33);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Multi-cycle control sequencer that drives the reg_file_alu datapath: RA1, RA2, WA, immediate, write_enable, ALUsrc and ALUControl, with Zero sampled back from it. It fetches 16-bit instructions from a synchronous instruction ROM, decodes them, sequences the ALU operation and register write-back, and resolves branches on Zero. It is the top-level control of the 8-bit CPU, with reg_file_alu as its datapath.

Parameters:
DATA_W, 8, datapath/immediate width (must match reg_file_alu)
RADDR_W, 4, register address width (16 registers)
PC_W, 8, program counter / instruction address width
IMEM_LAT, 1, instruction ROM read latency in cycles (1..3)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
start  input  1  begin execution from PC 0 (pulse)
instr_rd  output  1  ROM read strobe, 1 cycle
instr_addr  output  PC_W  ROM address (= PC)
instr_data  input  16  ROM data, valid IMEM_LAT cycles after instr_rd
Zero  input  1  datapath ALU zero flag
RA1  output  RADDR_W  register read address 1
RA2  output  RADDR_W  register read address 2
WA  output  RADDR_W  register write address
immediate  output  DATA_W  ALU immediate operand
write_enable  output  1  register write strobe
ALUsrc  output  1  0: B=reg[RA2], 1: B=immediate
ALUControl  output  2  00 AND, 01 OR, 10 ADD, 11 SUB
busy  output  1  executing (not IDLE/HALTED)
halted  output  1  HALT retired
illegal_op  output  1  sticky: undefined opcode seen
pc  output  PC_W  current program counter

Behaviour:
- Clock is CLK, reset is RST_N: asynchronous, active-low. All outputs are registered. Reset clears all outputs, PC and the latched instruction to 0 and puts the FSM in IDLE; write_enable drops immediately, even mid-WB.
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; for I-type, [7:0] imm8.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 AND, 3 OR, 4 SUB rd=rs1 op rs2: RA1=rs1, RA2=rs2, ALUsrc=0.
  - 5 LI rd=imm8: RA1=0, ALUsrc=1, OR. Requires R0==0.
  - 6 ADDI rd=rd+imm8: RA1=rd, ALUsrc=1, ADD.
  - 7 BEQZ rd,imm8: RA1=rd, RA2=0, ALUsrc=0, OR. If Zero, PC=imm8; otherwise PC+1.
  - 8 JMP imm8.
  - F HALT.
  - 9-E are illegal: set illegal_op (sticky until reset) and execute as NOP.
- FSM: IDLE -> FETCH -> WAIT -> EXEC -> WB -> FETCH.
  - IDLE: waits for start; on start, PC=0.
  - FETCH: instr_rd=1 for 1 cycle, instr_addr=PC.
  - WAIT: IMEM_LAT cycles; latch instr_data on the last cycle.
  - EXEC: drive RA1/RA2/immediate/ALUsrc/ALUControl and hold them through WB; sample Zero at the end of EXEC.
  - WB: write_enable=1 for exactly 1 cycle with WA=rd.
  - JMP, BEQZ, NOP and illegal ops skip WB (EXEC -> FETCH).
  - HALT goes EXEC -> HALTED: halted=1, busy=0, PC frozen at the HALT address.
- Writes with rd=0 are suppressed (write_enable stays 0), so R0 stays 0.
- PC increments in the last cycle of the instruction. PC wraps 0xFF -> 0x00. Branch/JMP target overrides the increment.
- Latency: ALU instructions take 3+IMEM_LAT cycles; branch/JMP/NOP take 2+IMEM_LAT.
- start while busy is ignored. start while HALTED clears halted, PC=0, goes to FETCH.
- Outside EXEC/WB, address/control outputs hold their last values; write_enable is 0.

Decomposition:
- Package cpu_pkg: opcode enum (NOP..HALT), ALUControl localparams (ALU_AND=00, ALU_OR=01, ALU_ADD=10, ALU_SUB=11), FSM state enum, instruction field-slice localparams.
- One sub-module, cpu_decoder: combinational opcode -> {ALUsrc, ALUControl, writes_rd, is_branch, is_jump, is_halt, illegal}.
- FSM, PC and latency counter stay in cpu_controller.
- The bench instantiates cpu_controller + reg_file_alu + ROM model.

Test Plan:
1. Reset asserted mid-WB of LI R1,0x11 -> write_enable falls immediately; all outputs 0, busy=0; R1 not written.
2. Program LI R1,0x11; LI R2,0x22; ADD R3,R1,R2; HALT -> R3=0x33, halted=1 after 3×4+3 cycles (IMEM_LAT=1); pc=3.
3. LI R3,0x33; LI R4,0x44; AND R5,R3,R4; BEQZ R5,0x10; at 0x10 OR R6,R3,R4; HALT -> branch taken, R6=0x77, pc=0x11.
4. BEQZ R1,0x20 with R1=0x11 -> not taken, PC=next; JMP 0xFF with NOP at 0xFF -> PC wraps to 0x00.
5. Opcode 0xA, then LI R0,0x55 -> illegal_op=1 and stays set, no write_enable pulse; R0 remains 0; start pulses while busy are ignored.
6. IMEM_LAT=3: program from scenario 2 -> same register results; instr_data is latched exactly 3 cycles after instr_rd.
